// File: rtl/boton_eventos_pkg.sv
// Shared types and constants for the button event stage.
package boton_eventos_pkg;

  localparam int unsigned NUM_BOTONES = 4;

  typedef enum logic [1:0] {
    IDLE,
    PRESIONADO,
    REPITIENDO
  } estado_t;

  typedef struct packed {
    logic       repeticion;
    logic [1:0] codigo;
  } evento_t;

endpackage

// File: rtl/boton_eventos_canal.sv
// One button channel: edge detect, hold/repeat FSM, press pulse and a single pending-event slot.
module boton_eventos_canal
  import boton_eventos_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned REPEAT_CYCLES = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic boton_i,
  input  logic grant_i,
  output logic pulso_o,
  output logic pend_o,
  output logic pend_rep_o,
  output logic drop_o
);

  localparam int unsigned CMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned CW   = $clog2(CMAX) + 1;
  localparam logic [CW-1:0] HOLD_FIN = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REP_FIN  = CW'(REPEAT_CYCLES - 1);

  estado_t       estado_q, estado_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          prev_q;
  logic          pulso_q, pulso_d;
  logic          pend_q, pend_d;
  logic          rep_q, rep_d;
  logic          evt, evt_rep;

  always_comb begin
    estado_d = estado_q;
    cnt_d    = cnt_q;
    pulso_d  = 1'b0;
    evt      = 1'b0;
    evt_rep  = 1'b0;
    if (!boton_i) begin
      estado_d = IDLE;
      cnt_d    = '0;
    end else begin
      unique case (estado_q)
        IDLE: begin
          if (!prev_q) begin
            estado_d = PRESIONADO;
            cnt_d    = '0;
            pulso_d  = 1'b1;
            evt      = 1'b1;
          end
        end
        PRESIONADO: begin
          if (cnt_q == HOLD_FIN) begin
            estado_d = REPITIENDO;
            cnt_d    = '0;
            evt      = 1'b1;
            evt_rep  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        REPITIENDO: begin
          if (cnt_q == REP_FIN) begin
            cnt_d   = '0;
            evt     = 1'b1;
            evt_rep = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: estado_d = IDLE;
      endcase
    end
  end

  // A slot granted this cycle is free again, so a new event may take it on the same edge.
  always_comb begin
    pend_d = pend_q & ~grant_i;
    rep_d  = rep_q;
    drop_o = evt & pend_q & ~grant_i;
    if (evt && !drop_o) begin
      pend_d = 1'b1;
      rep_d  = evt_rep;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q <= IDLE;
      cnt_q    <= '0;
      prev_q   <= 1'b0;
      pulso_q  <= 1'b0;
      pend_q   <= 1'b0;
      rep_q    <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      prev_q   <= boton_i;
      pulso_q  <= pulso_d;
      pend_q   <= pend_d;
      rep_q    <= rep_d;
    end
  end

  assign pulso_o    = pulso_q;
  assign pend_o     = pend_q;
  assign pend_rep_o = rep_q;

endmodule

// File: rtl/boton_eventos.sv
// Debounced buttons to press/repeat events: per-button channels, fixed-priority arbiter, event FIFO.
module boton_eventos
  import boton_eventos_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 16,
  parameter int unsigned REPEAT_CYCLES = 8,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [3:0]                  boton_debounce_i,
  output logic [3:0]                  pulso_o,
  output logic                        evento_valid_o,
  input  logic                        evento_ready_i,
  output logic [1:0]                  evento_codigo_o,
  output logic                        evento_repeticion_o,
  output logic [$clog2(FIFO_DEPTH):0] ocupacion_o,
  output logic                        overflow_o
);

  localparam int unsigned PW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNTW = PW + 1;

  logic [NUM_BOTONES-1:0] pend, pend_rep, grant, drop;

  for (genvar g = 0; g < NUM_BOTONES; g++) begin : g_canal
    boton_eventos_canal #(
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_canal (
      .clk       (clk),
      .rst       (rst),
      .boton_i   (boton_debounce_i[g]),
      .grant_i   (grant[g]),
      .pulso_o   (pulso_o[g]),
      .pend_o    (pend[g]),
      .pend_rep_o(pend_rep[g]),
      .drop_o    (drop[g])
    );
  end

  evento_t         mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_q, rd_q;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            overflow_q;
  logic            hay, lleno, push, pop;
  logic [1:0]      sel;
  evento_t         nuevo;

  always_comb begin
    sel = '0;
    hay = 1'b0;
    for (int unsigned i = 0; i < NUM_BOTONES; i++) begin
      if (pend[i] && !hay) begin
        hay = 1'b1;
        sel = 2'(i);
      end
    end
    lleno = (cnt_q == CNTW'(FIFO_DEPTH));
    pop   = (cnt_q != '0) && evento_ready_i;
    // Full FIFO still accepts when the head leaves on the same edge.
    push  = hay && (!lleno || pop);
    grant = '0;
    if (push) grant[sel] = 1'b1;
    nuevo.repeticion = pend_rep[sel];
    nuevo.codigo     = sel;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNTW'(1);
      2'b01:   cnt_d = cnt_q - CNTW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= nuevo;
        wr_q        <= wr_q + PW'(1);
      end
      if (pop) rd_q <= rd_q + PW'(1);
      cnt_q      <= cnt_d;
      overflow_q <= overflow_q | (|drop);
    end
  end

  assign evento_valid_o      = (cnt_q != '0);
  assign evento_codigo_o     = mem_q[rd_q].codigo;
  assign evento_repeticion_o = mem_q[rd_q].repeticion;
  assign ocupacion_o         = cnt_q;
  assign overflow_o          = overflow_q;

endmodule

// File: tb/tb_boton_eventos.sv
// Directed bench for boton_eventos built with HOLD_CYCLES=8, REPEAT_CYCLES=4, FIFO_DEPTH=4.
module tb_boton_eventos;

  logic       clk;
  logic       rst;
  logic [3:0] btn;
  logic [3:0] pulso;
  logic       valid;
  logic       rdy;
  logic [1:0] cod;
  logic       rep;
  logic [2:0] occ;
  logic       ovf;

  int total = 0;
  int bad   = 0;

  boton_eventos #(
    .HOLD_CYCLES  (8),
    .REPEAT_CYCLES(4),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .boton_debounce_i   (btn),
    .pulso_o            (pulso),
    .evento_valid_o     (valid),
    .evento_ready_i     (rdy),
    .evento_codigo_o    (cod),
    .evento_repeticion_o(rep),
    .ocupacion_o        (occ),
    .overflow_o         (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] btn;
    logic       rdy;
    logic [3:0] pulso;
    logic       valid;
    logic [1:0] cod;
    logic       rep;
    int         occ;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] p, input logic v,
                           input logic [1:0] c, input logic r, input int o);
    chk({tag, ".pulso"}, int'(pulso), int'(p));
    chk({tag, ".valid"}, int'(valid), int'(v));
    chk({tag, ".occ"}, int'(occ), o);
    if (v) begin
      chk({tag, ".codigo"}, int'(cod), int'(c));
      chk({tag, ".rep"}, int'(rep), int'(r));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    btn = 4'b0000;
    rdy = 1'b0;
    tick();
    tick();
    check_out("reset", 4'b0000, 1'b0, 2'd0, 1'b0, 0);
    chk("reset.ovf", int'(ovf), 0);
    #3 rst = 1'b0;

    // single short press of button 1, then buttons 0 and 2 together
    tbl[0] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 0};
    tbl[1] = '{4'b0010, 1'b1, 4'b0010, 1'b0, 2'd0, 1'b0, 0};
    tbl[2] = '{4'b0010, 1'b1, 4'b0000, 1'b1, 2'd1, 1'b0, 1};
    tbl[3] = '{4'b0010, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 0};
    tbl[4] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 0};
    tbl[5] = '{4'b0101, 1'b1, 4'b0101, 1'b0, 2'd0, 1'b0, 0};
    tbl[6] = '{4'b0101, 1'b1, 4'b0000, 1'b1, 2'd0, 1'b0, 1};
    tbl[7] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 1'b0, 1};
    tbl[8] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 0};
    for (int i = 0; i < 9; i++) begin
      btn = tbl[i].btn;
      rdy = tbl[i].rdy;
      tick();
      check_out($sformatf("vec%0d", i), tbl[i].pulso, tbl[i].valid, tbl[i].cod,
                tbl[i].rep, tbl[i].occ);
    end

    // hold button 0 for 40 edges: press at edge 0, repeats at 8,12,...,36
    rdy = 1'b1;
    for (int t = 0; t < 46; t++) begin
      int  e;
      logic ev;
      btn = (t < 40) ? 4'b0001 : 4'b0000;
      tick();
      e  = t - 1;
      ev = (e == 0) || (e >= 8 && e < 40 && ((e - 8) % 4) == 0);
      check_out($sformatf("hold%0d", t), (t == 0) ? 4'b0001 : 4'b0000, ev, 2'd0,
                (e != 0), ev ? 1 : 0);
    end

    // fill with ready=0, pending on a full FIFO, overflow, then push+pop while full
    rdy = 1'b0;
    btn = 4'b1111; tick(); check_out("fill0", 4'b1111, 1'b0, 2'd0, 1'b0, 0);
    btn = 4'b0000; tick(); check_out("fill1", 4'b0000, 1'b1, 2'd0, 1'b0, 1);
    tick(); check_out("fill2", 4'b0000, 1'b1, 2'd0, 1'b0, 2);
    tick(); check_out("fill3", 4'b0000, 1'b1, 2'd0, 1'b0, 3);
    tick(); check_out("fill4", 4'b0000, 1'b1, 2'd0, 1'b0, 4);
    btn = 4'b1000; tick(); check_out("pend3", 4'b1000, 1'b1, 2'd0, 1'b0, 4);
    btn = 4'b0000; tick(); check_out("rel3", 4'b0000, 1'b1, 2'd0, 1'b0, 4);
    chk("ovf.before", int'(ovf), 0);
    btn = 4'b1000; tick(); check_out("drop3", 4'b1000, 1'b1, 2'd0, 1'b0, 4);
    chk("ovf.after", int'(ovf), 1);
    btn = 4'b0000; rdy = 1'b1;
    tick(); check_out("drain0", 4'b0000, 1'b1, 2'd1, 1'b0, 4);
    tick(); check_out("drain1", 4'b0000, 1'b1, 2'd2, 1'b0, 3);
    tick(); check_out("drain2", 4'b0000, 1'b1, 2'd3, 1'b0, 2);
    tick(); check_out("drain3", 4'b0000, 1'b1, 2'd3, 1'b0, 1);
    tick(); check_out("drain4", 4'b0000, 1'b0, 2'd0, 1'b0, 0);
    chk("ovf.sticky", int'(ovf), 1);

    // reset while holding button 1 with three events queued
    rdy = 1'b0;
    btn = 4'b0010;
    tick(); check_out("rh0", 4'b0010, 1'b0, 2'd0, 1'b0, 0);
    for (int t = 1; t < 14; t++) tick();
    check_out("rh13", 4'b0000, 1'b1, 2'd1, 1'b0, 3);
    #2 rst = 1'b1;
    #1;
    check_out("rst.async", 4'b0000, 1'b0, 2'd0, 1'b0, 0);
    chk("rst.ovf", int'(ovf), 0);
    #2 rst = 1'b0;
    tick(); check_out("rel.press", 4'b0010, 1'b0, 2'd0, 1'b0, 0);
    tick(); check_out("rel.push", 4'b0000, 1'b1, 2'd1, 1'b0, 1);
    tick(); check_out("rel.one", 4'b0000, 1'b1, 2'd1, 1'b0, 1);
    chk("rel.ovf", int'(ovf), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/boton_eventos.md
Name: boton_eventos

Overview:
Consumes the 4-bit debounced button vector from the debounce stage and turns it into discrete events.
- Per-button press detection with one-cycle pulses.
- Auto-repeat while a button is held.
- A 4-deep event FIFO with valid/ready handshake toward the control FSM or display logic downstream.
- Single clock domain; no synchronisation of its own, because the input is already debounced and synchronous.

Parameters:
HOLD_CYCLES, 16, cycles a button must stay held after the press event before the first repeat event
REPEAT_CYCLES, 8, cycles between consecutive repeat events while held (must be >= 1)
FIFO_DEPTH, 4, event FIFO entries (power of two, >= 2)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
boton_debounce_i  input  4  debounced buttons, 1 = pressed
pulso_o  output  4  one-cycle pulse per button on press (rising edge only, never on repeat)
evento_valid_o  output  1  FIFO head holds an event
evento_ready_i  input  1  consumer accepts the head when valid && ready
evento_codigo_o  output  2  button index of the head event
evento_repeticion_o  output  1  head event is an auto-repeat (0 = initial press)
ocupacion_o  output  $clog2(FIFO_DEPTH)+1  FIFO entry count
overflow_o  output  1  sticky flag: an event was dropped; cleared only by rst

Behaviour:
- Reset (async assert, sync to clk on release):
  - all outputs 0
  - previous-sample register 0000, so a button already high at reset release produces a press on the first edge
  - channel FSMs IDLE, counters 0, pending bits 0, FIFO empty
- Per-button channel FSM, states IDLE / PRESIONADO / REPITIENDO:
  - IDLE: input=1 and prev=0 -> PRESIONADO; pulse, press event, counter cleared.
  - PRESIONADO: counter increments each cycle; when counter reaches HOLD_CYCLES-1 -> REPITIENDO with a repeat event and counter cleared.
  - REPITIENDO: a repeat event every REPEAT_CYCLES cycles.
  - Input=0 in any state -> IDLE next edge; no event on release.
- Timing:
  - Input sampled high at edge k: pulso_o high for exactly the cycle following edge k, and the pending bit is set at edge k.
  - First repeat event is raised HOLD_CYCLES edges after the press event.
- Pending/arbitration:
  - Each channel has one pending slot {repeticion}.
  - Each cycle, the lowest-index pending channel is pushed if the FIFO is not full, or is full but popping the same cycle; its slot clears.
  - One push per cycle maximum.
  - A new event on a channel whose slot is still occupied is dropped and sets overflow_o. The older event is retained.
- FIFO:
  - Registered storage; head drives the outputs directly.
  - Push at edge k+1 makes evento_valid_o high after that edge: 2-cycle latency from input sample to valid when uncontended.
  - Pop on valid && ready.
  - Push+pop in the same cycle leaves occupancy unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - ocupacion_o is exact, 0..FIFO_DEPTH.
  - A pop when empty is ignored.
- Reset mid-operation discards all pending and queued events immediately (async).

Decomposition:
- Package boton_eventos_pkg:
  - estado_t enum {IDLE, PRESIONADO, REPITIENDO}
  - evento_t packed struct {logic repeticion; logic [1:0] codigo;}
  - NUM_BOTONES = 4
- Sub-module boton_eventos_canal: one FSM, counter, edge detect and pending slot, instantiated 4x via generate.
- Arbiter and FIFO are inline in the top.

Test Plan:
- Press button 1 for 3 cycles, ready=1 (HOLD=16):
  - pulso_o = 0010 for one cycle
  - valid high 2 cycles after the sample, with codigo=1, repeticion=0
  - exactly one event, no repeats
- Hold button 0 for 40 cycles, HOLD=8, REPEAT=4, ready=1:
  - one press event
  - then repeat events at 8, 12, 16, ... cycles after the press event
  - stop on release
- Buttons 0 and 2 rise on the same edge, ready=1:
  - pulso_o = 0101
  - FIFO receives codigo 0, then codigo 2 on consecutive pushes
- ready=0, press 4 buttons then 1 more press on button 3:
  - ocupacion_o reaches 4, evento_valid_o stays high
  - a further button-3 event while its slot is pending sets overflow_o
  - draining with ready=1 yields 0, 1, 2, 3, 3
- FIFO full with ready=1 and a pending event in the same cycle:
  - simultaneous push/pop
  - occupancy stays 4, order preserved
- Assert rst mid-hold with 3 events queued:
  - outputs go 0 immediately
  - after release with the button still held, one fresh press event appears
